// File: rtl/vmem_pkg.sv
// Shared types and constants for the vector memory sequencer.
package vmem_pkg;

   localparam int unsigned DW    = 16;
   localparam int unsigned LANES = 16;
   localparam int unsigned AW    = 16;
   localparam int unsigned VW    = DW * LANES;
   localparam int unsigned BW    = $clog2(LANES);

   localparam logic [BW-1:0] LAST_BEAT = BW'(LANES - 1);

   typedef logic [LANES-1:0][DW-1:0] vec_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      FETCH_WAIT,
      VRD,
      VRD_DRAIN,
      VWR,
      VDONE
   } state_e;

   typedef enum logic {
      RQ_FETCH = 1'b0,
      RQ_VEC   = 1'b1
   } req_id_e;

endpackage

// File: rtl/vmem_seq_if.sv
// Fetch, vector and SRAM signals of the memory sequencer.
// VMEM_STRIDE_EN adds the signed per-lane stride input v_stride.
interface vmem_seq_if;
   import vmem_pkg::*;

   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_valid;
   logic [DW-1:0] if_rdata;

   logic          v_req;
   logic          v_we;
   logic [AW-1:0] v_base;
   logic [VW-1:0] v_wdata;
`ifdef VMEM_STRIDE_EN
   logic [7:0]    v_stride;
`endif
   logic          v_busy;
   logic          v_done;
   logic [VW-1:0] v_rdata;

   logic [AW-1:0] mem_addr;
   logic          mem_rd;
   logic          mem_wr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, v_req, v_we, v_base, v_wdata, mem_rdata,
`ifdef VMEM_STRIDE_EN
      input  v_stride,
`endif
      output if_gnt, if_valid, if_rdata, v_busy, v_done, v_rdata,
      output mem_addr, mem_rd, mem_wr, mem_wdata
   );

   modport master (
      output if_req, if_addr, v_req, v_we, v_base, v_wdata, mem_rdata,
`ifdef VMEM_STRIDE_EN
      output v_stride,
`endif
      input  if_gnt, if_valid, if_rdata, v_busy, v_done, v_rdata,
      input  mem_addr, mem_rd, mem_wr, mem_wdata
   );

endinterface

// File: rtl/vmem_lane_buf.sv
// Vector working buffer: parallel load, single-lane write, single-lane read.
module vmem_lane_buf
   import vmem_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_i,
   input  vec_t          load_data_i,
   input  logic          wr_i,
   input  logic [BW-1:0] wr_idx_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic [BW-1:0] rd_idx_i,
   output logic [DW-1:0] rd_data_c_o,
   output vec_t          buf_o
);

   vec_t buf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q <= '0;
      end else if (load_i) begin
         buf_q <= load_data_i;
      end else if (wr_i) begin
         buf_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_data_c_o = buf_q[rd_idx_i];
   assign buf_o       = buf_q;

endmodule

// File: rtl/vmem_seq.sv
// SRAM sequencer: round-robin between fetch and vector, vector ops split into lane beats.
// VMEM_STRIDE_EN enables a signed per-lane address stride (otherwise stride is 1).
module vmem_seq
   import vmem_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   vmem_seq_if.slave  bus
);

   state_e        state_q, state_d;
   req_id_e       rr_q, rr_d;
   logic [BW-1:0] cnt_q, cnt_d;
   logic          if_gnt_q, if_gnt_d;
   logic          if_valid_q, if_valid_d;
   logic          mem_rd_q, mem_rd_d;
   logic          mem_wr_q, mem_wr_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          v_busy_q, v_busy_d;
   logic          v_done_q, v_done_d;
   vec_t          v_rdata_q, v_rdata_d;

   logic          vec_acc_c;
   logic          fetch_win_c;
   logic          cap_c;
   logic [DW-1:0] wr_lane_c;
   logic [AW-1:0] stride_c;
   vec_t          buf_c;
   vec_t          vld_vec_c;

`ifdef VMEM_STRIDE_EN
   logic [AW-1:0] stride_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stride_q <= '0;
      end else if (vec_acc_c) begin
         stride_q <= {{(AW-8){bus.v_stride[7]}}, bus.v_stride};
      end
   end

   assign stride_c = stride_q;
`else
   assign stride_c = AW'(1);
`endif

   // Read data lags its beat by one cycle; the drain state lands on lane LANES-1.
   assign cap_c = ((state_q == VRD) && (cnt_q != '0)) || (state_q == VRD_DRAIN);

   vmem_lane_buf u_lane_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (vec_acc_c & bus.v_we),
      .load_data_i (vec_t'(bus.v_wdata)),
      .wr_i        (cap_c),
      .wr_idx_i    (BW'(cnt_q - 1'b1)),
      .wr_data_i   (bus.mem_rdata),
      .rd_idx_i    (BW'(cnt_q + 1'b1)),
      .rd_data_c_o (wr_lane_c),
      .buf_o       (buf_c)
   );

   always_comb begin
      vld_vec_c            = buf_c;
      vld_vec_c[LANES-1]   = bus.mem_rdata;
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      cnt_d       = cnt_q;
      if_gnt_d    = 1'b0;
      if_valid_d  = 1'b0;
      mem_rd_d    = 1'b0;
      mem_wr_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      v_busy_d    = v_busy_q;
      v_done_d    = 1'b0;
      v_rdata_d   = v_rdata_q;
      vec_acc_c   = 1'b0;
      fetch_win_c = bus.if_req && (!bus.v_req || (rr_q == RQ_VEC));

      unique case (state_q)
         IDLE: begin
            if (fetch_win_c) begin
               state_d    = FETCH;
               rr_d       = RQ_FETCH;
               if_gnt_d   = 1'b1;
               mem_rd_d   = 1'b1;
               mem_addr_d = bus.if_addr;
            end else if (bus.v_req) begin
               vec_acc_c  = 1'b1;
               rr_d       = RQ_VEC;
               cnt_d      = '0;
               v_busy_d   = 1'b1;
               mem_addr_d = bus.v_base;
               if (bus.v_we) begin
                  state_d     = VWR;
                  mem_wr_d    = 1'b1;
                  mem_wdata_d = bus.v_wdata[DW-1:0];
               end else begin
                  state_d  = VRD;
                  mem_rd_d = 1'b1;
               end
            end
         end
         FETCH: begin
            state_d    = FETCH_WAIT;
            if_valid_d = 1'b1;
         end
         FETCH_WAIT: state_d = IDLE;
         VRD: begin
            cnt_d = BW'(cnt_q + 1'b1);
            if (cnt_q == LAST_BEAT) begin
               state_d = VRD_DRAIN;
            end else begin
               mem_rd_d   = 1'b1;
               mem_addr_d = mem_addr_q + stride_c;
            end
         end
         VRD_DRAIN: begin
            state_d   = VDONE;
            v_done_d  = 1'b1;
            v_rdata_d = vld_vec_c;
         end
         VWR: begin
            cnt_d = BW'(cnt_q + 1'b1);
            if (cnt_q == LAST_BEAT) begin
               state_d  = VDONE;
               v_done_d = 1'b1;
            end else begin
               mem_wr_d    = 1'b1;
               mem_addr_d  = mem_addr_q + stride_c;
               mem_wdata_d = wr_lane_c;
            end
         end
         VDONE: begin
            state_d  = IDLE;
            v_busy_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_q        <= RQ_VEC;
         cnt_q       <= '0;
         if_gnt_q    <= 1'b0;
         if_valid_q  <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         v_busy_q    <= 1'b0;
         v_done_q    <= 1'b0;
         v_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         cnt_q       <= cnt_d;
         if_gnt_q    <= if_gnt_d;
         if_valid_q  <= if_valid_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         v_busy_q    <= v_busy_d;
         v_done_q    <= v_done_d;
         v_rdata_q   <= v_rdata_d;
      end
   end

   assign bus.if_gnt    = if_gnt_q;
   assign bus.if_valid  = if_valid_q;
   // Fetched word comes straight off the SRAM bus during the valid cycle.
   assign bus.if_rdata  = if_valid_q ? bus.mem_rdata : '0;
   assign bus.mem_rd    = mem_rd_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.v_busy    = v_busy_q;
   assign bus.v_done    = v_done_q;
   assign bus.v_rdata   = v_rdata_q;

endmodule

// File: tb/tb_vmem_seq.sv
// Directed bench for vmem_seq with a behavioural single-port SRAM.
module tb_vmem_seq;
   import vmem_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   vmem_seq_if bus();

   vmem_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] sram [0:(1<<AW)-1];
   logic [DW-1:0] rdata_q = '0;
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;

   always @(posedge clk) begin
      if (pl_en) sram[pl_addr] <= pl_data;
      else if (bus.mem_wr) sram[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_rd) rdata_q <= sram[bus.mem_addr];
   end
   assign bus.mem_rdata = rdata_q;

   logic [AW-1:0] rd_log[$];
   logic [AW-1:0] wa_log[$];
   logic [DW-1:0] wd_log[$];
   int both_hi = 0;

   always @(negedge clk) begin
      if (bus.mem_rd) rd_log.push_back(bus.mem_addr);
      if (bus.mem_wr) begin
         wa_log.push_back(bus.mem_addr);
         wd_log.push_back(bus.mem_wdata);
      end
      if (bus.mem_rd && bus.mem_wr) both_hi++;
   end

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic clear_logs();
      rd_log.delete(); wa_log.delete(); wd_log.delete();
   endtask

   // Issue one vector op and wait (bounded) for v_done; done_cyc = -1 on timeout.
   task automatic run_vec(input logic we, input logic [AW-1:0] base, input logic [VW-1:0] wd,
                          output int done_cyc, output logic busy1);
      bus.v_req = 1'b1; bus.v_we = we; bus.v_base = base; bus.v_wdata = wd;
      done_cyc = -1; busy1 = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) busy1 = bus.v_busy;
         if (bus.v_done) begin
            done_cyc = c;
            break;
         end
      end
      bus.v_req = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({bus.if_gnt, bus.if_valid, bus.v_busy, bus.v_done, bus.mem_rd, bus.mem_wr} !== 6'b0) begin
         bad++; $display("FAIL reset_strobes got=%b exp=000000",
            {bus.if_gnt, bus.if_valid, bus.v_busy, bus.v_done, bus.mem_rd, bus.mem_wr});
      end
      total++;
      if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata} !== '0) begin
         bad++; $display("FAIL reset_buses got=%h exp=0", {bus.mem_addr, bus.mem_wdata, bus.if_rdata});
      end
      total++;
      if (bus.v_rdata !== '0) begin bad++; $display("FAIL reset_vrdata got=%h exp=0", bus.v_rdata); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({bus.if_gnt, bus.v_busy, bus.mem_rd, bus.mem_wr} !== 4'b0) begin
         bad++; $display("FAIL idle_no_req got=%b exp=0000", {bus.if_gnt, bus.v_busy, bus.mem_rd, bus.mem_wr});
      end
   endtask

   task automatic test_fetch();
      preload(16'h0040, 16'hA5C3);
      clear_logs();
      bus.if_req = 1'b1; bus.if_addr = 16'h0040;
      @(negedge clk);
      total++;
      if ({bus.if_gnt, bus.mem_rd, bus.if_valid} !== 3'b110 || bus.mem_addr !== 16'h0040) begin
         bad++; $display("FAIL fetch_c1 got=%b/%h exp=110/0040", {bus.if_gnt, bus.mem_rd, bus.if_valid}, bus.mem_addr);
      end
      @(negedge clk);
      total++;
      if ({bus.if_gnt, bus.mem_rd, bus.if_valid} !== 3'b001) begin
         bad++; $display("FAIL fetch_c2 got=%b exp=001", {bus.if_gnt, bus.mem_rd, bus.if_valid});
      end
      total++;
      if (bus.if_rdata !== 16'hA5C3) begin bad++; $display("FAIL fetch_rdata got=%h exp=a5c3", bus.if_rdata); end
      bus.if_req = 1'b0;
      @(negedge clk);
      total++;
      if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL fetch_valid_pulse got=%b exp=0", bus.if_valid); end
      repeat (2) @(negedge clk);
      total++;
      if (rd_log.size() != 1) begin bad++; $display("FAIL fetch_rd_count got=%0d exp=1", rd_log.size()); end
   endtask

   task automatic test_vld();
      int dc;
      logic b1;
      for (int k = 0; k < 16; k++) preload(AW'(16'h0100 + k), DW'(16'h1000 + k));
      clear_logs();
      run_vec(1'b0, 16'h0100, '0, dc, b1);
      total++;
      if (dc != 18) begin bad++; $display("FAIL vld_latency got=%0d exp=18", dc); end
      total++;
      if (b1 !== 1'b1) begin bad++; $display("FAIL vld_busy got=%b exp=1", b1); end
      @(negedge clk);
      total++;
      if ({bus.v_done, bus.v_busy} !== 2'b00) begin
         bad++; $display("FAIL vld_done_pulse got=%b exp=00", {bus.v_done, bus.v_busy});
      end
      for (int k = 0; k < 16; k++) begin
         total++;
         if (bus.v_rdata[k*DW +: DW] !== DW'(16'h1000 + k)) begin
            bad++; $display("FAIL vld_lane%0d got=%h exp=%h", k, bus.v_rdata[k*DW +: DW], DW'(16'h1000 + k));
         end
      end
      total++;
      if (rd_log.size() != 16 || wa_log.size() != 0) begin
         bad++; $display("FAIL vld_beats got=%0d/%0d exp=16/0", rd_log.size(), wa_log.size());
      end
      for (int k = 0; k < rd_log.size(); k++) begin
         total++;
         if (rd_log[k] !== AW'(16'h0100 + k)) begin
            bad++; $display("FAIL vld_addr%0d got=%h exp=%h", k, rd_log[k], AW'(16'h0100 + k));
         end
      end
   endtask

   task automatic test_vst_wrap();
      int dc;
      logic b1;
      logic [VW-1:0] wd;
      for (int k = 0; k < 16; k++) wd[k*DW +: DW] = DW'(16'hB000 + k);
      clear_logs();
      run_vec(1'b1, 16'hFFF8, wd, dc, b1);
      total++;
      if (dc != 17) begin bad++; $display("FAIL vst_latency got=%0d exp=17", dc); end
      @(negedge clk);
      total++;
      if (wa_log.size() != 16 || rd_log.size() != 0) begin
         bad++; $display("FAIL vst_beats got=%0d/%0d exp=16/0", wa_log.size(), rd_log.size());
      end
      for (int k = 0; k < wa_log.size(); k++) begin
         total++;
         if (wa_log[k] !== AW'(32'hFFF8 + k) || wd_log[k] !== DW'(16'hB000 + k)) begin
            bad++; $display("FAIL vst_beat%0d got=%h:%h exp=%h:%h", k, wa_log[k], wd_log[k],
                            AW'(32'hFFF8 + k), DW'(16'hB000 + k));
         end
      end
      total++;
      if (sram[16'h0003] !== 16'hB00B) begin bad++; $display("FAIL vst_sram got=%h exp=b00b", sram[16'h0003]); end
      total++;
      if (bus.v_rdata[DW-1:0] !== 16'h1000) begin
         bad++; $display("FAIL vst_vrdata_hold got=%h exp=1000", bus.v_rdata[DW-1:0]);
      end
   endtask

   task automatic test_contention();
      int g[$];
      int gnt_cyc = -1, valid_cyc = -1, busy_cyc = -1;
      logic prev = 1'b0;
      rst_n = 1'b0;
      bus.if_req = 1'b1; bus.if_addr = 16'h0040;
      bus.v_req = 1'b1; bus.v_we = 1'b0; bus.v_base = 16'h0100;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (bus.if_gnt) begin
            g.push_back(0);
            if (gnt_cyc < 0) gnt_cyc = c;
         end
         if (bus.if_valid && valid_cyc < 0) valid_cyc = c;
         if (bus.v_busy && !prev) begin
            g.push_back(1);
            if (busy_cyc < 0) busy_cyc = c;
         end
         prev = bus.v_busy;
         if (g.size() >= 3) break;
      end
      bus.if_req = 1'b0; bus.v_req = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         int got;
         got = (i < g.size()) ? g[i] : -1;
         total++;
         if (got != (i == 1 ? 1 : 0)) begin
            bad++; $display("FAIL rr_grant%0d got=%0d exp=%0d", i, got, (i == 1 ? 1 : 0));
         end
      end
      total++;
      if (gnt_cyc != 1) begin bad++; $display("FAIL rr_first_gnt got=%0d exp=1", gnt_cyc); end
      total++;
      if (busy_cyc - valid_cyc != 2) begin
         bad++; $display("FAIL rr_reaccept_gap got=%0d exp=2", busy_cyc - valid_cyc);
      end
   endtask

   task automatic test_reset_mid_vld();
      int dc, nd;
      logic b1;
      for (int k = 0; k < 16; k++) preload(AW'(16'h0200 + k), DW'(16'h2000 + k));
      bus.v_req = 1'b1; bus.v_we = 1'b0; bus.v_base = 16'h0200;
      repeat (8) @(negedge clk);
      total++;
      if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0207) begin
         bad++; $display("FAIL beat7 got=%b/%h exp=1/0207", bus.mem_rd, bus.mem_addr);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.v_busy, bus.v_done, bus.mem_rd, bus.mem_wr, bus.mem_addr} !== '0) begin
         bad++; $display("FAIL midrst_outputs got=%h exp=0", {bus.v_busy, bus.v_done, bus.mem_rd, bus.mem_wr, bus.mem_addr});
      end
      total++;
      if (bus.v_rdata !== '0) begin bad++; $display("FAIL midrst_vrdata got=%h exp=0", bus.v_rdata); end
      bus.v_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      repeat (25) begin
         @(negedge clk);
         if (bus.v_done) nd++;
      end
      total++;
      if (nd != 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", nd); end
      run_vec(1'b0, 16'h0200, '0, dc, b1);
      total++;
      if (dc != 18) begin bad++; $display("FAIL midrst_relatency got=%0d exp=18", dc); end
      for (int k = 0; k < 16; k++) begin
         total++;
         if (bus.v_rdata[k*DW +: DW] !== DW'(16'h2000 + k)) begin
            bad++; $display("FAIL midrst_lane%0d got=%h exp=%h", k, bus.v_rdata[k*DW +: DW], DW'(16'h2000 + k));
         end
      end
      @(negedge clk);
   endtask

`ifdef VMEM_STRIDE_EN
   task automatic test_stride();
      int dc;
      logic b1;
      for (int k = 0; k < 16; k++) preload(AW'(32'h0020 - 2*k), DW'(16'h3000 + k));
      clear_logs();
      bus.v_stride = 8'hFE;
      run_vec(1'b0, 16'h0020, '0, dc, b1);
      total++;
      if (dc != 18 || rd_log.size() != 16) begin
         bad++; $display("FAIL stride_neg_beats got=%0d/%0d exp=18/16", dc, rd_log.size());
      end
      for (int k = 0; k < rd_log.size(); k++) begin
         total++;
         if (rd_log[k] !== AW'(32'h0020 - 2*k) || bus.v_rdata[k*DW +: DW] !== DW'(16'h3000 + k)) begin
            bad++; $display("FAIL stride_neg%0d got=%h:%h exp=%h:%h", k, rd_log[k], bus.v_rdata[k*DW +: DW],
                            AW'(32'h0020 - 2*k), DW'(16'h3000 + k));
         end
      end
      @(negedge clk);
      preload(16'h0050, 16'h4444);
      clear_logs();
      bus.v_stride = 8'h00;
      run_vec(1'b0, 16'h0050, '0, dc, b1);
      for (int k = 0; k < 16; k++) begin
         total++;
         if (bus.v_rdata[k*DW +: DW] !== 16'h4444 || (k < rd_log.size() && rd_log[k] !== 16'h0050)) begin
            bad++; $display("FAIL stride_zero%0d got=%h exp=4444", k, bus.v_rdata[k*DW +: DW]);
         end
      end
      bus.v_stride = 8'h01;
      @(negedge clk);
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.v_req = 1'b0; bus.v_we = 1'b0; bus.v_base = '0; bus.v_wdata = '0;
`ifdef VMEM_STRIDE_EN
      bus.v_stride = 8'h01;
`endif
      test_reset();
      test_fetch();
      test_vld();
      test_vst_wrap();
      test_contention();
      test_reset_mid_vld();
`ifdef VMEM_STRIDE_EN
      test_stride();
`endif
      total++;
      if (both_hi != 0) begin bad++; $display("FAIL rd_wr_exclusive got=%0d exp=0", both_hi); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vmem_seq.md
Name: vmem_seq

Overview:
Memory sequencer between the single-port 16-bit SRAM and two requesters: the instruction-fetch path and the vector load/store unit.
- Arbitrates SRAM ownership between the two requesters.
- Breaks each VLD/VST into LANES single-word SRAM beats.
- Assembles or drains the 256-bit vector buffer and reports completion.
- Replaces the ad-hoc RD/WR control and the vld_done/vst_done generation in the CPU top level.

Parameters:
DW, 16, SRAM word width and vector lane width
LANES, 16, lanes per vector; vector width is DW*LANES
AW, 16, SRAM address width

Ports:
clk  in  1  single system clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
if_req  in  1  fetch request, level, held until if_valid
if_addr  in  AW  fetch address (PC)
if_gnt  out  1  one-cycle pulse: fetch accepted and issuing
if_valid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DW  fetched instruction word
v_req  in  1  vector request, level, held until v_done
v_we  in  1  1 = VST, 0 = VLD; sampled at accept
v_base  in  AW  vector base address; sampled at accept
v_wdata  in  DW*LANES  store data; sampled at accept
v_busy  out  1  high from accept until v_done inclusive
v_done  out  1  one-cycle completion pulse
v_rdata  out  DW*LANES  loaded vector; stable from v_done until the next VLD accept
mem_addr  out  AW  SRAM address
mem_rd  out  1  SRAM read strobe; data returns on mem_rdata next cycle
mem_wr  out  1  SRAM write strobe
mem_wdata  out  DW  SRAM write data
mem_rdata  in  DW  SRAM read data

Behaviour:
Reset values (async, rst_n=0):
- All outputs 0; v_rdata cleared.
- State IDLE; beat counter 0; rr_last=VEC.
- Reset mid-operation aborts the op with no done/valid pulse. Requesters re-issue.

FSM states: IDLE, FETCH, FETCH_WAIT, VRD, VRD_DRAIN, VWR, VDONE.

IDLE and arbitration:
- Only one request pending: grant it.
- Both pending: round-robin. Grant the one not equal to rr_last; update rr_last on each grant. After reset, fetch wins the first tie.
- Grant to fetch: go to FETCH. Grant to vector: latch v_we/v_base/v_wdata, then go to VWR if v_we=1, else VRD.

Fetch (accept edge at t0):
- FETCH (cycle 1): mem_rd=1, mem_addr=if_addr, if_gnt=1.
- FETCH_WAIT (cycle 2): if_valid=1, if_rdata=mem_rdata.
- Then IDLE. Fetch latency is 2 cycles after accept.

VLD:
- VRD for beats k=0..LANES-1, one per cycle: mem_rd=1, mem_addr=base+k*stride.
- Data for beat k arrives one cycle later and is written to lane k, bits [DW*k+DW-1 : DW*k].
- VRD_DRAIN captures the last beat.
- VDONE: v_done=1, then IDLE.
- Total: LANES+2 cycles accept→done (18 at default).

VST:
- VWR for beats k=0..LANES-1: mem_wr=1, mem_addr=base+k*stride, mem_wdata=latched lane k.
- Then VDONE, then IDLE. LANES+1 cycles (17).

Address arithmetic:
- Modulo 2^AW; wrap from 0xFFFF to 0x0000 is silent.
- Stride is 1 unless the optional feature is compiled in.

Invariants:
- mem_rd and mem_wr are never both 1.
- In IDLE and VDONE, mem_rd=mem_wr=0.
- Request deassertion mid-op is ignored; the op completes.
- A new request is not accepted in the same cycle as v_done or if_valid. The earliest re-accept is the following IDLE cycle.
- v_busy=1 in VRD/VRD_DRAIN/VWR/VDONE.

Optional Feature:
VMEM_STRIDE_EN
- Defined: adds port v_stride (in, 8, signed lane stride), sampled at accept. Beat address = base + sext(v_stride)*k, mod 2^AW. Stride 0 is legal and repeats the address; for VLD every lane gets the same word.
- Undefined: no v_stride port; stride fixed to 1.

Decomposition:
Package vmem_pkg:
- FSM state encoding.
- DW, LANES, AW defaults.
- Requester IDs (FETCH, VEC) for rr_last.
- Lane-slice helper constants (beat counter width = clog2(LANES)).

Sub-module vmem_lane_buf:
- DW*LANES register with parallel load (for VST latch).
- Indexed lane write (for VLD capture) and indexed lane read (for VST beats).

Test Plan:
- Fetch only: if_req=1, if_addr=0x0040, SRAM[0x40]=0xA5C3 -> if_gnt in cycle 1, if_valid=1 with if_rdata=0xA5C3 in cycle 2, mem_rd high exactly 1 cycle.
- VLD: base=0x0100, SRAM[0x100+k]=0x1000+k -> v_done 18 cycles after accept; v_rdata lane k = 0x1000+k; 16 mem_rd pulses, addresses 0x0100..0x010F.
- VST wrap: base=0xFFF8, lane k=0xB000+k -> 16 writes to 0xFFF8..0xFFFF then 0x0000..0x0007; v_done at cycle 17; mem_rd never asserted.
- Contention: if_req and v_req both high from reset -> fetch granted first, vector next. With both held continuously, grants alternate FETCH,VEC,FETCH.
- Reset mid-VLD: rst_n low at beat 7 -> all outputs 0 immediately; no v_done. After release, a new VLD completes normally.
- (VMEM_STRIDE_EN) stride=-2, base=0x0020 -> addresses 0x0020, 0x001E, … 0x0002. Stride=0 -> all lanes equal SRAM[base].
